// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Decode-side handshake bundle of the instruction fetch queue.
//               The master (fetch_queue) presents the head entry; the slave
//               (decode / CCG1) accepts it with out_ready.
//   out_valid  head entry valid                     (master -> slave)
//   out_ready  decode accepts the head entry        (slave  -> master)
//   out_instr  head 16-bit instruction word         (master -> slave)
//   out_pc     address of the head instruction      (master -> slave)
//   out_npc    out_pc + 1, modulo 256               (master -> slave)
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic [7:0]  out_npc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        output out_npc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_npc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch stage. Owns the fetch PC, drives the
//               combinational program memory, buffers {instr, pc} pairs in a
//               DEPTH-entry FIFO and hands them to decode over a valid/ready
//               handshake. A redirect (PC load) flushes the queue and restarts
//               fetch at redirect_addr after a one-cycle FLUSH state.
// Ports       :
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   en             fetch enable (0 holds the fetch PC, decode may still drain)
//   pm_addr        program memory address (= fetch PC)
//   pm_data        program memory word, combinational from pm_addr
//   redirect       PC load request, flushes the queue
//   redirect_addr  new fetch target
//   out_if         decode handshake (fetch_queue_if.master)
//   level          registered FIFO occupancy
//   redirect_cnt   (FETCH_QUEUE_PERF_EN only) saturating redirect-cycle count
//   stall_cnt      (FETCH_QUEUE_PERF_EN only) saturating count of cycles with
//                  out_ready=1 and out_valid=0
// Options     : define FETCH_QUEUE_PERF_EN to add the performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  wire                      clk,
    input  wire                      rst_n,
    input  wire                      en,
    output logic [7:0]               pm_addr,
    input  wire  [15:0]              pm_data,
    input  wire                      redirect,
    input  wire  [7:0]               redirect_addr,
    fetch_queue_if.master            out_if,
    output logic [$clog2(DEPTH):0]   level
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [15:0]              redirect_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [7:0]    pc_q,     pc_d;
    logic [CW-1:0] count_q,  count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    // Each entry holds {instruction word, its address}.
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   mem_d [DEPTH];

    logic          valid;
    logic          pop;
    logic          push;

    always_comb begin
        // FLUSH always sees an empty queue, but gating on the state keeps the
        // head invisible even if a flush and stale count ever coincide.
        valid = (count_q != '0) && (state_q != S_FLUSH);
        pop   = valid && out_if.out_ready;
        // A full queue can still accept a word when the head leaves this cycle.
        push  = (state_q == S_RUN) && en && !redirect
                && ((count_q != C_DEPTH) || pop);

        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_IDLE;
            S_FLUSH: state_d = en ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {pm_data, pc_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            pc_d            = pc_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Redirect overrides everything, including an entry popped this cycle
        // (decode has already taken it) and re-entry while already flushing.
        if (redirect) begin
            state_d  = S_FLUSH;
            pc_d     = redirect_addr;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign pm_addr = pc_q;
    assign level   = count_q;

    // Head fields read as zero whenever nothing is presented.
    assign out_if.out_valid = valid;
    assign out_if.out_instr = valid ? mem_q[rd_ptr_q][23:8] : 16'h0000;
    assign out_if.out_pc    = valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign out_if.out_npc   = valid ? (mem_q[rd_ptr_q][7:0] + 8'd1) : 8'h00;

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic [15:0] stall_cnt_q,    stall_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
        if (out_if.out_ready && !valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
//               Program memory returns 16'h1000 + address. A vector table
//               drives en/out_ready/redirect cycle by cycle and states the
//               expected head/level/pm_addr after each edge; entries expected
//               to be consumed by decode go into a scoreboard that a negedge
//               monitor checks on every handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic [7:0]  pm_addr;
    logic [15:0] pm_data;
    logic [2:0]  level;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;
`endif

    fetch_queue_if dq ();

    always #5 clk = ~clk;

    assign pm_data = {8'h10, pm_addr};

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pm_addr       (pm_addr),
        .pm_data       (pm_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .out_if        (dq),
        .level         (level)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .redirect_cnt  (redirect_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    typedef struct packed {
        logic       en;
        logic       rdy;
        logic       redir;
        logic [7:0] raddr;
        logic       pop;      // decode is expected to consume pop_pc before this edge
        logic [7:0] pop_pc;
        logic       valid;    // expected after the edge
        logic [7:0] pc;
        logic [2:0] lvl;
        logic [7:0] pm;
    } vec_t;

    vec_t       vecs [23];
    logic [7:0] sb [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_redir = 0;
    int         exp_stall = 0;

    function automatic vec_t mk(input logic e, input logic r, input logic d,
                                input logic [7:0] ra, input logic p,
                                input logic [7:0] ppc, input logic v,
                                input logic [7:0] pc, input logic [2:0] l,
                                input logic [7:0] pm);
        vec_t t;
        t = '{en: e, rdy: r, redir: d, raddr: ra, pop: p, pop_pc: ppc,
              valid: v, pc: pc, lvl: l, pm: pm};
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decode-side monitor: every handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect) exp_redir++;
            if (dq.out_ready && !dq.out_valid) exp_stall++;
            if (dq.out_valid && dq.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %h, expected no pop", dq.out_pc);
                end else begin
                    logic [7:0] e_pc;
                    logic [7:0] e_npc;
                    e_pc  = sb.pop_front();
                    e_npc = e_pc + 8'd1;
                    chk("pop_pc",    16'(dq.out_pc),  16'(e_pc));
                    chk("pop_instr", dq.out_instr,    {8'h10, e_pc});
                    chk("pop_npc",   16'(dq.out_npc), 16'(e_npc));
                end
            end
        end
    end

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            en            = vecs[i].en;
            dq.out_ready  = vecs[i].rdy;
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            if (vecs[i].pop) sb.push_back(vecs[i].pop_pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 16'(dq.out_valid), 16'(vecs[i].valid));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i),    16'(dq.out_pc), 16'(vecs[i].pc));
                chk($sformatf("v%0d_instr", i), dq.out_instr,   {8'h10, vecs[i].pc});
            end
            chk($sformatf("v%0d_level", i), 16'(level),   16'(vecs[i].lvl));
            chk($sformatf("v%0d_pm", i),    16'(pm_addr), 16'(vecs[i].pm));
        end
    endtask

    initial begin
        //               en rdy red raddr  pop ppc    valid pc    lvl   pm
        // streaming: one word per cycle, level never above 1
        vecs[0]  = mk(H, H, L, 8'h00, L, 8'h00, L, 8'h00, 3'd0, 8'h00);
        vecs[1]  = mk(H, H, L, 8'h00, L, 8'h00, H, 8'h00, 3'd1, 8'h01);
        vecs[2]  = mk(H, H, L, 8'h00, H, 8'h00, H, 8'h01, 3'd1, 8'h02);
        vecs[3]  = mk(H, H, L, 8'h00, H, 8'h01, H, 8'h02, 3'd1, 8'h03);
        // decode stalls: fill to DEPTH, head stays put, fetch PC holds when full
        vecs[4]  = mk(H, L, L, 8'h00, L, 8'h00, H, 8'h02, 3'd2, 8'h04);
        vecs[5]  = mk(H, L, L, 8'h00, L, 8'h00, H, 8'h02, 3'd3, 8'h05);
        vecs[6]  = mk(H, L, L, 8'h00, L, 8'h00, H, 8'h02, 3'd4, 8'h06);
        vecs[7]  = mk(H, L, L, 8'h00, L, 8'h00, H, 8'h02, 3'd4, 8'h06);
        // full with a pop: push and pop together, level stays at DEPTH
        vecs[8]  = mk(H, H, L, 8'h00, H, 8'h02, H, 8'h03, 3'd4, 8'h07);
        // en=0 drains without fetching, leaving 3 entries
        vecs[9]  = mk(L, H, L, 8'h00, H, 8'h03, H, 8'h04, 3'd3, 8'h07);
        // redirect to 8'h40 with 3 buffered entries
        vecs[10] = mk(H, L, H, 8'h40, L, 8'h00, L, 8'h00, 3'd0, 8'h40);
        vecs[11] = mk(H, H, L, 8'h00, L, 8'h00, L, 8'h00, 3'd0, 8'h40);
        vecs[12] = mk(H, H, L, 8'h00, L, 8'h00, H, 8'h40, 3'd1, 8'h41);
        vecs[13] = mk(H, H, L, 8'h00, H, 8'h40, H, 8'h41, 3'd1, 8'h42);
        // redirect together with a pop, then a second redirect while flushing
        vecs[14] = mk(H, H, H, 8'h80, H, 8'h41, L, 8'h00, 3'd0, 8'h80);
        vecs[15] = mk(H, H, H, 8'hFE, L, 8'h00, L, 8'h00, 3'd0, 8'hFE);
        vecs[16] = mk(H, H, L, 8'h00, L, 8'h00, L, 8'h00, 3'd0, 8'hFE);
        // address wrap 8'hFE -> 8'hFF -> 8'h00
        vecs[17] = mk(H, H, L, 8'h00, L, 8'h00, H, 8'hFE, 3'd1, 8'hFF);
        vecs[18] = mk(H, H, L, 8'h00, H, 8'hFE, H, 8'hFF, 3'd1, 8'h00);
        vecs[19] = mk(H, H, L, 8'h00, H, 8'hFF, H, 8'h00, 3'd1, 8'h01);
        // restart after the mid-burst reset
        vecs[20] = mk(H, H, L, 8'h00, L, 8'h00, L, 8'h00, 3'd0, 8'h00);
        vecs[21] = mk(H, H, L, 8'h00, L, 8'h00, H, 8'h00, 3'd1, 8'h01);
        vecs[22] = mk(H, H, L, 8'h00, H, 8'h00, H, 8'h01, 3'd1, 8'h02);

        dq.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(dq.out_valid), 16'h0000);
        chk("rst_level", 16'(level),        16'h0000);
        chk("rst_pm",    16'(pm_addr),      16'h0000);
        chk("rst_instr", dq.out_instr,      16'h0000);
        chk("rst_pc",    16'(dq.out_pc),    16'h0000);
        chk("rst_npc",   16'(dq.out_npc),   16'h0000);
        rst_n = 1'b1;

        run(0, 19);

`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_redirect_cnt", redirect_cnt, 16'(exp_redir));
        chk("perf_stall_cnt",    stall_cnt,    16'(exp_stall));
`endif

        // Asynchronous reset in the middle of a burst, well away from any edge.
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_redir = 0;
        exp_stall = 0;
        #1;
        chk("async_rst_valid", 16'(dq.out_valid), 16'h0000);
        chk("async_rst_level", 16'(level),        16'h0000);
        chk("async_rst_pm",    16'(pm_addr),      16'h0000);
`ifdef FETCH_QUEUE_PERF_EN
        chk("async_rst_redirect_cnt", redirect_cnt, 16'h0000);
        chk("async_rst_stall_cnt",    stall_cnt,    16'h0000);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(20, 22);

        chk("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
